// File: rtl/cond_unit.sv
// Execute-stage condition unit: holds the NZCV flags register, evaluates CondE,
// gates write/branch controls and registers them into Memory. Optional macro:
// COND_UNIT_ANNUL_COUNT_EN enables a saturating annulled-instruction counter.
module cond_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       ALUFlags,
  input  logic [3:0]       CondE,
  input  logic             ValidE,
  input  logic [1:0]       FlagWriteE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             PCSrcE,
  input  logic             StallE,
  input  logic             FlushE,
  output logic             CondExE,
  output logic [3:0]       Flags,
  output logic             ValidM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             PCSrcM,
  output logic [CNT_W-1:0] AnnulCount
);

  logic flag_n, flag_z, flag_c, flag_v;
  logic pass;

  assign {flag_n, flag_z, flag_c, flag_v} = Flags;

  // Condition decode reads the committed flags register only, never ALUFlags
  always_comb begin
    CondExE = 1'b0;
    case (CondE)
      4'b0000: CondExE = flag_z;
      4'b0001: CondExE = ~flag_z;
      4'b0010: CondExE = flag_c;
      4'b0011: CondExE = ~flag_c;
      4'b0100: CondExE = flag_n;
      4'b0101: CondExE = ~flag_n;
      4'b0110: CondExE = flag_v;
      4'b0111: CondExE = ~flag_v;
      4'b1000: CondExE = flag_c & ~flag_z;
      4'b1001: CondExE = ~flag_c | flag_z;
      4'b1010: CondExE = (flag_n == flag_v);
      4'b1011: CondExE = (flag_n != flag_v);
      4'b1100: CondExE = ~flag_z & (flag_n == flag_v);
      4'b1101: CondExE = flag_z | (flag_n != flag_v);
      4'b1110: CondExE = 1'b1;
      default: CondExE = 1'b0;
    endcase
  end

  assign pass = ValidE & ~FlushE & CondExE;

  // Flags register: NZ and CV halves load independently
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Flags <= 4'b0000;
    end else if (!StallE && pass) begin
      if (FlagWriteE[1]) Flags[3:2] <= ALUFlags[3:2];
      if (FlagWriteE[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

  // Memory-stage register; flush wins over stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ValidM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      PCSrcM    <= 1'b0;
    end else if (FlushE) begin
      ValidM    <= 1'b0;
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
      PCSrcM    <= 1'b0;
    end else if (!StallE) begin
      ValidM    <= ValidE;
      RegWriteM <= RegWriteE & pass;
      MemWriteM <= MemWriteE & pass;
      PCSrcM    <= PCSrcE & pass;
    end
  end

`ifdef COND_UNIT_ANNUL_COUNT_EN
  logic annul;

  assign annul = ValidE & ~FlushE & ~CondExE;

  // Saturating count of real instructions killed by their condition
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      AnnulCount <= '0;
    end else if (!StallE && annul && (AnnulCount != {CNT_W{1'b1}})) begin
      AnnulCount <= AnnulCount + CNT_W'(1);
    end
  end
`else
  assign AnnulCount = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: directed scenarios plus random traffic checked
// against a rule-level reference model; a monitor compares each cycle's M state.
module tb_cond_unit;

`ifdef COND_UNIT_ANNUL_COUNT_EN
  localparam int unsigned CNT_W = 2;
`else
  localparam int unsigned CNT_W = 16;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic [3:0]       ALUFlags, CondE;
  logic             ValidE, RegWriteE, MemWriteE, PCSrcE, StallE, FlushE;
  logic [1:0]       FlagWriteE;
  logic             CondExE, ValidM, RegWriteM, MemWriteM, PCSrcM;
  logic [3:0]       Flags;
  logic [CNT_W-1:0] AnnulCount;

  typedef struct packed {
    logic             vm;
    logic             rw;
    logic             mw;
    logic             pc;
    logic [3:0]       flags;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  logic [3:0] m_flags;
  logic       m_vm, m_rw, m_mw, m_pc;
  int         m_cnt;

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .ALUFlags(ALUFlags), .CondE(CondE),
    .ValidE(ValidE), .FlagWriteE(FlagWriteE), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .PCSrcE(PCSrcE), .StallE(StallE), .FlushE(FlushE),
    .CondExE(CondExE), .Flags(Flags), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .PCSrcM(PCSrcM), .AnnulCount(AnnulCount)
  );

  always #5 clk = ~clk;

  // ARM encoding: cond[3:1] picks a base test, cond[0] inverts it; 1111 never runs
  function automatic logic cond_ok(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'b1111) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  function automatic exp_t model_snapshot();
    exp_t e;
    e.vm = m_vm; e.rw = m_rw; e.mw = m_mw; e.pc = m_pc;
    e.flags = m_flags;
`ifdef COND_UNIT_ANNUL_COUNT_EN
    e.cnt = CNT_W'(m_cnt);
`else
    e.cnt = '0;
`endif
    return e;
  endfunction

  task automatic model_reset();
    m_flags = 4'b0000; m_vm = 1'b0; m_rw = 1'b0; m_mw = 1'b0; m_pc = 1'b0;
    m_cnt = 0;
  endtask

  task automatic set_idle();
    ValidE = 1'b0; CondE = 4'b1110; FlagWriteE = 2'b00; ALUFlags = 4'b0000;
    RegWriteE = 1'b0; MemWriteE = 1'b0; PCSrcE = 1'b0; StallE = 1'b0; FlushE = 1'b0;
  endtask

  // Drive one Execute cycle, check CondExE, advance the model, push expectation
  task automatic step(input logic v, input logic [3:0] c, input logic [1:0] fw,
                      input logic [3:0] af, input logic rw, input logic mw,
                      input logic pc, input logic st, input logic fl);
    logic ok, p;
    @(negedge clk);
    ValidE = v; CondE = c; FlagWriteE = fw; ALUFlags = af;
    RegWriteE = rw; MemWriteE = mw; PCSrcE = pc; StallE = st; FlushE = fl;
    #1;
    ok = cond_ok(m_flags, c);
    n_cmp++;
    if (CondExE !== ok) begin
      n_err++;
      $display("FAIL condex: cond=%b flags=%b got %b expected %b", c, m_flags, CondExE, ok);
    end
    p = v && !fl && ok;
    if (fl) begin
      m_vm = 1'b0; m_rw = 1'b0; m_mw = 1'b0; m_pc = 1'b0;
    end else if (!st) begin
      m_vm = v; m_rw = rw && p; m_mw = mw && p; m_pc = pc && p;
    end
    if (!st && p) begin
      if (fw[1]) m_flags[3:2] = af[3:2];
      if (fw[0]) m_flags[1:0] = af[1:0];
    end
    if (!st && v && !fl && !ok && m_cnt < (2 ** CNT_W) - 1) m_cnt++;
    sb_q.push_back(model_snapshot());
  endtask

  task automatic check_flags(input logic [3:0] want, input string name);
    @(posedge clk); #2;
    n_cmp++;
    if (Flags !== want) begin
      n_err++;
      $display("FAIL %s: Flags got %b expected %b", name, Flags, want);
    end
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({Flags, ValidM, RegWriteM, MemWriteM, PCSrcM, AnnulCount} !== '0) begin
      n_err++;
      $display("FAIL %s: flags=%b vm=%b rw=%b mw=%b pc=%b cnt=%0d expected all zero",
               name, Flags, ValidM, RegWriteM, MemWriteM, PCSrcM, AnnulCount);
    end
  endtask

  // Monitor: compare registered outputs after every edge that has an expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_cmp++;
      if ({ValidM, RegWriteM, MemWriteM, PCSrcM, Flags, AnnulCount} !== e) begin
        n_err++;
        $display("FAIL mstage: got vm=%b rw=%b mw=%b pc=%b flags=%b cnt=%0d expected vm=%b rw=%b mw=%b pc=%b flags=%b cnt=%0d",
                 ValidM, RegWriteM, MemWriteM, PCSrcM, Flags, AnnulCount,
                 e.vm, e.rw, e.mw, e.pc, e.flags, e.cnt);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    set_idle();
    model_reset();
    #3;
    check_zero("reset_state");
    @(negedge clk);
    reset_n = 1'b1;

    // NZ-only write straight after reset
    step(1, 4'b1110, 2'b10, 4'b0100, 0, 0, 0, 0, 0);
    check_flags(4'b0100, "nz_write");
    // Conditional annul (NE fails) then pass (EQ)
    step(1, 4'b0001, 2'b00, 4'b0000, 1, 1, 0, 0, 0);
    step(1, 4'b0000, 2'b00, 4'b0000, 1, 1, 0, 0, 0);
    // Signed compares
    step(1, 4'b1110, 2'b11, 4'b1000, 0, 0, 0, 0, 0);
    step(1, 4'b1011, 2'b00, 4'b0000, 1, 0, 0, 0, 0);
    step(1, 4'b1100, 2'b00, 4'b0000, 1, 0, 0, 0, 0);
    step(1, 4'b1110, 2'b01, 4'b0001, 0, 0, 0, 0, 0);
    check_flags(4'b1001, "flags_1001");
    step(1, 4'b1010, 2'b00, 4'b0000, 1, 0, 0, 0, 0);
    // Split write, then failed-condition instruction must not write
    step(1, 4'b1110, 2'b11, 4'b0000, 0, 0, 0, 0, 0);
    step(1, 4'b1110, 2'b01, 4'b1111, 0, 0, 0, 0, 0);
    check_flags(4'b0011, "cv_split");
    step(1, 4'b0000, 2'b11, 4'b0100, 1, 1, 1, 0, 0);
    check_flags(4'b0011, "failed_no_write");
    // Stall holds, stall+flush clears M
    step(1, 4'b1110, 2'b11, 4'b1010, 1, 0, 1, 1, 0);
    step(1, 4'b1110, 2'b11, 4'b1010, 1, 0, 1, 1, 1);
    // Set-then-test back to back
    step(1, 4'b1110, 2'b10, 4'b0100, 0, 0, 0, 0, 0);
    step(1, 4'b0000, 2'b00, 4'b0000, 1, 0, 1, 0, 0);
    // Annulled burst (saturates when the counter is narrow)
    for (int i = 0; i < 5; i++) step(1, 4'b1111, 2'b11, 4'b1111, 1, 1, 1, 0, 0);

    // Async reset between edges with live M state and Flags=1111
    step(1, 4'b1110, 2'b11, 4'b1111, 1, 1, 1, 0, 0);
    step(1, 4'b1110, 2'b00, 4'b0000, 1, 0, 0, 0, 0);
    check_flags(4'b1111, "pre_reset_flags");
    #1;
    reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    set_idle();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 8, 4'($urandom), 2'($urandom), 4'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);
    end

    @(posedge clk); #3;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
